// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x-oversampling 8N1 UART receiver.
// Holds the FSM state encoding and the oversampling counter landmarks.
`timescale 1ns/1ps
package uart_rx_os16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Oversampling landmarks: mid start bit, and one full bit period later.
  localparam logic [3:0] OS_MID   = 4'd7;
  localparam logic [3:0] OS_LAST  = 4'd15;
  localparam logic [2:0] BIT_LAST = 3'd7;

  function automatic logic [3:0] os_next(input logic [3:0] cnt);
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/uart_rx_os16_baud_tick_acc.sv
// Phase-accumulator tick generator: the carry out of a free-running
// accumulator, registered so each tick lasts exactly one clock.
`timescale 1ns/1ps
module baud_tick_acc #(
  parameter int unsigned ACC_BITS = 24,
  parameter int unsigned INC      = 309238
) (
  input  logic clk_100M,
  input  logic rst_n,
  output logic o_tick
);

  localparam logic [ACC_BITS:0] W_INC = (ACC_BITS + 1)'(INC);

  logic [ACC_BITS-1:0] r_acc;
  logic                r_tick;
  logic [ACC_BITS:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + W_INC;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_sum[ACC_BITS-1:0];
      r_tick <= w_sum[ACC_BITS];
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with a 16x oversampling tick, valid/ready output,
// one-cycle framing-error pulse and sticky overrun flag.
`timescale 1ns/1ps
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int unsigned ACC_BITS    = 24,
  parameter int unsigned INC         = 309238,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic                   w_tick;
  logic                   w_rxs;
  logic                   w_hs;
  logic [SYNC_STAGES-1:0] r_sync;

  rx_state_t  r_state;
  logic [3:0] r_os_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_frame_err;
  logic       r_overrun;
  logic       r_busy;
  logic       r_line_seen_high;

  baud_tick_acc #(
    .ACC_BITS (ACC_BITS),
    .INC      (INC)
  ) u_tick (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= rxd;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];
  assign w_hs  = r_rx_valid && rx_ready;

  // Handshake is applied first so a byte completing in the same cycle wins.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_os_cnt         <= '0;
      r_bit_cnt        <= '0;
      r_shift          <= '0;
      r_rx_data        <= '0;
      r_rx_valid       <= 1'b0;
      r_frame_err      <= 1'b0;
      r_overrun        <= 1'b0;
      r_busy           <= 1'b0;
      r_line_seen_high <= 1'b1;
    end else begin
      r_frame_err <= 1'b0;
      if (w_hs) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_rxs) begin
              r_line_seen_high <= 1'b1;
            end else if (r_line_seen_high) begin
              r_state          <= ST_START;
              r_busy           <= 1'b1;
              r_os_cnt         <= '0;
              r_line_seen_high <= 1'b0;
            end
          end
          ST_START: begin
            if (r_os_cnt == OS_MID) begin
              r_os_cnt <= '0;
              if (w_rxs) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end
            end else begin
              r_os_cnt <= os_next(r_os_cnt);
            end
          end
          ST_DATA: begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt  <= '0;
              r_shift   <= {w_rxs, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_os_cnt <= os_next(r_os_cnt);
            end
          end
          ST_STOP: begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt <= '0;
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              if (w_rxs) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_hs) begin
                  r_overrun <= 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_os_cnt <= os_next(r_os_cnt);
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_os_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: table-driven frames, hand-written corner cases and
// randomized back-to-back traffic checked against an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  // Tick rate raised 8x (921600 baud) to keep the run short.
  localparam int unsigned TB_INC  = 309238 * 8;
  localparam real         BIT_NOM = 1.0e9 / 921600.0;
  localparam real         TICK_NS = 16777216.0 / TB_INC * 10.0;

  logic       clk_100M;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_os16 #(
    .ACC_BITS    (24),
    .INC         (TB_INC),
    .SYNC_STAGES (2)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  rcvq[$];
  logic [7:0]  expq[$];
  int unsigned valid_rises;
  int unsigned valid_cycles;
  int unsigned ferr_cycles;
  logic        prev_valid = 1'b0;
  realtime     t_rise;

  always @(negedge clk_100M) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && rx_ready) rcvq.push_back(rx_data);
      if (rx_valid && !prev_valid) begin
        valid_rises++;
        if (valid_rises == 1) t_rise = $realtime;
      end
      if (rx_valid)  valid_cycles++;
      if (frame_err) ferr_cycles++;
      prev_valid = rx_valid;
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $realtime);
    end
  endtask

  task automatic clear_counters();
    rcvq.delete();
    valid_rises  = 0;
    valid_cycles = 0;
    ferr_cycles  = 0;
  endtask

  // Leaves rxd at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] d, input logic stop, input real bt);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(bt);
    end
    rxd = stop;
    #(bt);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    real         scale;
    int unsigned exp_bytes;
    int unsigned exp_ferr;
  } vec_t;

  vec_t    vecs[6];
  realtime t_edge;
  real     lat;
  real     f;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1.00, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0.98, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1.02, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 1.00, 0, 1};
    vecs[4] = '{8'h5A, 1'b1, 1.02, 1, 0};
    vecs[5] = '{8'h81, 1'b1, 0.98, 1, 0};

    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    clear_counters();
    #100;
    check("reset_rx_data",   rx_data,   0);
    check("reset_rx_valid",  rx_valid,  0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun",   overrun,   0);
    check("reset_busy",      busy,      0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    #(2.0 * BIT_NOM);

    for (int i = 0; i < 6; i++) begin
      clear_counters();
      t_edge = $realtime;
      send_frame(vecs[i].data, vecs[i].stop, BIT_NOM * vecs[i].scale);
      #(BIT_NOM);
      rxd = 1'b1;
      #(2.0 * BIT_NOM);
      check($sformatf("vec%0d_valid_rises", i), valid_rises, vecs[i].exp_bytes);
      check($sformatf("vec%0d_valid_cycles", i), valid_cycles, vecs[i].exp_bytes);
      check($sformatf("vec%0d_frame_err", i), ferr_cycles, vecs[i].exp_ferr);
      check($sformatf("vec%0d_overrun", i), overrun, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vecs[i].exp_bytes == 1) begin
        check($sformatf("vec%0d_nbytes", i), rcvq.size(), 1);
        if (rcvq.size() > 0) check($sformatf("vec%0d_data", i), rcvq[0], vecs[i].data);
      end
      if (i == 0) begin
        lat = t_rise - t_edge;
        check("latency_window",
              ((lat >= 9.5 * BIT_NOM - 10.0) && (lat <= 9.5 * BIT_NOM + TICK_NS + 60.0)) ? 1 : 0, 1);
      end
    end

    // Framing error with the line held low afterwards: no re-trigger.
    clear_counters();
    send_frame(8'h3C, 1'b0, BIT_NOM);
    #(3.0 * BIT_NOM);
    check("ferr_pulse_cycles", ferr_cycles, 1);
    check("ferr_no_valid", valid_rises, 0);
    check("ferr_low_no_restart", busy, 0);
    rxd = 1'b1;
    #(2.0 * BIT_NOM);
    send_frame(8'h55, 1'b1, BIT_NOM);
    #(2.0 * BIT_NOM);
    check("ferr_recover_nbytes", rcvq.size(), 1);
    if (rcvq.size() > 0) check("ferr_recover_data", rcvq[0], 8'h55);

    // Short low glitch is rejected at mid start bit.
    clear_counters();
    rxd = 1'b0;
    #(180);
    check("glitch_busy_rises", busy, 1);
    #(70);
    rxd = 1'b1;
    #(BIT_NOM);
    check("glitch_back_idle", busy, 0);
    check("glitch_no_valid", valid_rises, 0);
    check("glitch_no_ferr", ferr_cycles, 0);
    #(BIT_NOM);

    // Back-to-back bursts at the edges of the baud tolerance.
    for (int g = 0; g < 3; g++) begin
      clear_counters();
      expq.delete();
      f = (g == 0) ? 0.98 : (g == 1) ? 1.02 : $urandom_range(980, 1020) / 1000.0;
      for (int k = 0; k < 5; k++) begin
        logic [7:0] b;
        b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        expq.push_back(b);
        send_frame(b, 1'b1, BIT_NOM * f);
      end
      #(3.0 * BIT_NOM);
      check($sformatf("burst%0d_nbytes", g), rcvq.size(), expq.size());
      for (int k = 0; k < expq.size(); k++) begin
        if (k < rcvq.size()) check($sformatf("burst%0d_byte%0d", g, k), rcvq[k], expq[k]);
      end
      check($sformatf("burst%0d_ferr", g), ferr_cycles, 0);
    end

    // Overrun: two bytes without consumption, then a single-cycle handshake.
    clear_counters();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT_NOM);
    #(BIT_NOM);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_no_ovr", overrun, 0);
    send_frame(8'h22, 1'b1, BIT_NOM);
    #(2.0 * BIT_NOM);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_flag", overrun, 1);
    @(negedge clk_100M);
    rx_ready = 1'b1;
    @(negedge clk_100M);
    rx_ready = 1'b0;
    #1;
    check("ovr_hs_valid", rx_valid, 0);
    check("ovr_hs_flag", overrun, 0);

    // Reset during bit 4 of 0x5A, with a pending overrun byte as well.
    send_frame(8'h77, 1'b1, BIT_NOM);
    send_frame(8'h66, 1'b1, BIT_NOM);
    #(BIT_NOM);
    check("rst_pre_overrun", overrun, 1);
    rxd = 1'b0;
    #(BIT_NOM);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h5A >> i) & 8'h01;
      #(BIT_NOM);
    end
    rxd = 1'b1;
    #(0.3 * BIT_NOM);
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #20;
    check("rst_mid_rx_data",   rx_data,   0);
    check("rst_mid_rx_valid",  rx_valid,  0);
    check("rst_mid_frame_err", frame_err, 0);
    check("rst_mid_overrun",   overrun,   0);
    check("rst_mid_busy",      busy,      0);
    rx_ready = 1'b1;
    #(BIT_NOM);
    @(negedge clk_100M);
    rst_n = 1'b1;
    clear_counters();
    #(2.0 * BIT_NOM);
    send_frame(8'hC3, 1'b1, BIT_NOM);
    #(2.0 * BIT_NOM);
    check("rst_after_nbytes", rcvq.size(), 1);
    if (rcvq.size() > 0) check("rst_after_data", rcvq[0], 8'hC3);
    check("rst_after_ferr", ferr_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Receive end of the debug serial link: 8N1 UART receiver for the serial line clocked by the phase-accumulator baud generator.
- Generates its own 16x oversampling tick from clk_100M with a phase accumulator, so it is not tied to a fixed integer divisor.
- Delivers each received byte through a valid/ready handshake to the debug logic.
- Flags framing errors and overruns.

Parameters:
- ACC_BITS, 24, phase accumulator width.
- INC, 309238, accumulator increment per clk_100M cycle; tick rate = 100 MHz * INC / 2^ACC_BITS (≈1.8432 MHz = 16 x 115200).
- SYNC_STAGES, 2, metastability flops on rxd.

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous reset, active low.
- rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte, LSB received first.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky; set when a byte completes while rx_valid is still high; cleared by a handshake.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): accumulator=0, synchronizer flops=1, state=IDLE, os_cnt=0, bit_cnt=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Tick:
  - acc <= acc + INC (ACC_BITS+1-bit sum).
  - tick = carry out, registered, so it is one clk_100M cycle wide.
  - Accumulator runs freely and is never realigned to rxd edges.
- rxs = rxd after SYNC_STAGES flops; all decisions use rxs.
- State machine. All transitions below occur only on tick cycles unless stated.
  - IDLE: on a tick with rxs=0 -> START, os_cnt=0.
  - START: os_cnt increments per tick. At os_cnt=7 (mid start bit):
    - rxs=1 -> IDLE (glitch rejected, no flags).
    - rxs=0 -> DATA, os_cnt=0, bit_cnt=0.
  - DATA: os_cnt increments per tick. At os_cnt=15:
    - shift <= {rxs, shift[7:1]}, bit_cnt++, os_cnt=0.
    - After the 8th sample -> STOP.
  - STOP: at os_cnt=15, sample rxs.
    - rxs=1: rx_data <= shift; rx_valid <= 1; if rx_valid was already 1 and not handshaken in this cycle, overrun <= 1.
    - rxs=0: frame_err pulses one cycle; rx_data and rx_valid unchanged.
    - Both cases -> IDLE.
- Re-arm: in IDLE a new start bit is accepted on the next tick with rxs=0. A stop bit held low does not re-trigger until rxs has gone high and low again. Track this with a `line_seen_high` flag: set when rxs=1 in IDLE, required before leaving IDLE; reset value 1.
- Handshake:
  - rx_valid && rx_ready in a clk_100M cycle -> rx_valid <= 0 next cycle, overrun <= 0.
  - Same cycle as a new byte completing: new byte wins, rx_valid stays 1, overrun not set.
- Overrun: the newer byte overwrites rx_data.
- Latency: rx_valid rises 1 clk_100M cycle after the mid-stop-bit tick. This is about 9.5 bit times after the start edge, plus synchronizer delay (SYNC_STAGES cycles) and up to one tick of phase uncertainty.
- Widths: os_cnt 4 bits, wraps 15->0. bit_cnt 3 bits, plus the DATA->STOP decision on bit_cnt=7 at the sample.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.

Decomposition:
- Shared package: state encoding (IDLE, START, DATA, STOP) and OS_MID=7 / OS_LAST=15 constants.
- One natural sub-module: baud_tick_acc, holding the phase accumulator and the registered carry tick, with parameters ACC_BITS and INC.
- Synchronizer and FSM stay inline.

Test Plan:
- Basic byte: send 0xA5 at 115200 with rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5; frame_err=0, overrun=0.
- Glitch: drive rxd low for 2 us, then high -> state returns to IDLE; no rx_valid, no frame_err.
- Framing error: send 0x3C with stop bit low -> frame_err single pulse; rx_valid stays 0; no new start until rxd returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_valid=1, rx_data=0x22, overrun=1. Assert rx_ready for 1 cycle -> rx_valid=0, overrun=0.
- Baud tolerance: back-to-back 0x00 and 0xFF frames at ±2% baud -> all bytes received correctly.
- Async reset mid-frame: pull rst_n low during bit 4 of 0x5A, release, then send 0xC3 -> only 0xC3 is delivered; all outputs at reset values during reset.
